// File: rtl/control_sequencer_if.sv
// Handshake and control bundle between the instruction source, the
// timestep sequencer and the 10-bit bus datapath.
`timescale 1ns/1ps
interface control_sequencer_if;
   logic       EXEC;
   logic [9:0] INSTR;
   logic [1:0] TIME;
   logic       DONE;
   logic       EXT_OUT;
   logic [3:0] ROUT;
   logic [3:0] RIN;
   logic       A_LD;
   logic       G_LD;
   logic       G_OUT;
   logic [2:0] ALU_OP;

   modport master (
      output EXEC, INSTR,
      input  TIME, DONE, EXT_OUT, ROUT, RIN, A_LD, G_LD, G_OUT, ALU_OP
   );

   modport slave (
      input  EXEC, INSTR,
      output TIME, DONE, EXT_OUT, ROUT, RIN, A_LD, G_LD, G_OUT, ALU_OP
   );
endinterface

// File: rtl/control_sequencer.sv
// Timestep sequencer: latches an instruction on EXEC and walks T0..T3,
// generating bus-source, register-load and ALU controls for each step.
`timescale 1ns/1ps
module control_sequencer #(
   parameter int HOLD_CYCLES = 0
) (
   input  logic                CLK,
   input  logic                RESETb,
   control_sequencer_if.slave  bus
);

   localparam int            CW       = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);

   typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_done;
   logic [6:0]    r_ir;

   state_t        w_state_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_done_nxt;
   logic          w_ir_ld;
   logic          w_final;
   logic [2:0]    w_op;
   logic [1:0]    w_rx;
   logic [1:0]    w_ry;
   logic          w_unused_rsvd;

   assign w_op          = r_ir[6:4];
   assign w_rx          = r_ir[3:2];
   assign w_ry          = r_ir[1:0];
   assign w_final       = (r_cnt == HOLD_MAX);
   assign w_unused_rsvd = ^bus.INSTR[2:0];

   always_ff @(posedge CLK or negedge RESETb) begin
      if (!RESETb) begin
         r_state <= T0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_ir    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
         if (w_ir_ld) r_ir <= bus.INSTR[9:3];
      end
   end

   // LOAD and MOV finish after T1; every ALU op runs through T3.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = r_done;
      w_ir_ld     = 1'b0;
      case (r_state)
         T0: begin
            w_cnt_nxt = '0;
            if (bus.EXEC) begin
               w_ir_ld     = 1'b1;
               w_done_nxt  = 1'b0;
               w_state_nxt = T1;
            end
         end
         T1, T2, T3: begin
            if (!w_final) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end else begin
               w_cnt_nxt = '0;
               if (r_state == T3 || (r_state == T1 && w_op[2:1] == 2'b00)) begin
                  w_state_nxt = T0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = state_t'(r_state + 2'd1);
               end
            end
         end
         default: w_state_nxt = T0;
      endcase
   end

   // Drive-type outputs span the whole step; load strobes fire on its final cycle.
   always_comb begin
      bus.EXT_OUT = 1'b0;
      bus.ROUT    = 4'b0000;
      bus.RIN     = 4'b0000;
      bus.A_LD    = 1'b0;
      bus.G_LD    = 1'b0;
      bus.G_OUT   = 1'b0;
      bus.ALU_OP  = 3'b000;
      case (r_state)
         T1: begin
            if (w_op == 3'b000) begin
               bus.EXT_OUT = 1'b1;
               bus.RIN     = w_final ? (4'b0001 << w_rx) : 4'b0000;
            end else if (w_op == 3'b001) begin
               bus.ROUT    = 4'b0001 << w_ry;
               bus.RIN     = w_final ? (4'b0001 << w_rx) : 4'b0000;
            end else begin
               bus.ROUT    = 4'b0001 << w_rx;
               bus.A_LD    = w_final;
            end
         end
         T2: begin
            if (w_op != 3'b111) bus.ROUT = 4'b0001 << w_ry;
            bus.G_LD   = w_final;
            bus.ALU_OP = w_op;
         end
         T3: begin
            bus.G_OUT = 1'b1;
            bus.RIN   = w_final ? (4'b0001 << w_rx) : 4'b0000;
         end
         default: ;
      endcase
   end

   assign bus.TIME = r_state;
   assign bus.DONE = r_done;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed and random-stream bench for control_sequencer at HOLD_CYCLES 0..3.
`timescale 1ns/1ps
module tb_control_sequencer;

   logic CLK;
   logic RESETb;
   int   n_tests;
   int   n_fail;
   logic chk_en;

   control_sequencer_if if0 ();
   control_sequencer_if if1 ();
   control_sequencer_if if2 ();
   control_sequencer_if if3 ();

   control_sequencer #(.HOLD_CYCLES(0)) u_dut0 (.CLK(CLK), .RESETb(RESETb), .bus(if0.slave));
   control_sequencer #(.HOLD_CYCLES(1)) u_dut1 (.CLK(CLK), .RESETb(RESETb), .bus(if1.slave));
   control_sequencer #(.HOLD_CYCLES(2)) u_dut2 (.CLK(CLK), .RESETb(RESETb), .bus(if2.slave));
   control_sequencer #(.HOLD_CYCLES(3)) u_dut3 (.CLK(CLK), .RESETb(RESETb), .bus(if3.slave));

   // {EXT_OUT, ROUT, RIN, A_LD, G_LD, G_OUT, ALU_OP}
   logic [14:0] ctl0, ctl2;
   assign ctl0 = {if0.EXT_OUT, if0.ROUT, if0.RIN, if0.A_LD, if0.G_LD, if0.G_OUT, if0.ALU_OP};
   assign ctl2 = {if2.EXT_OUT, if2.ROUT, if2.RIN, if2.A_LD, if2.G_LD, if2.G_OUT, if2.ALU_OP};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         n_tests++;
         if ($countones({if0.EXT_OUT, if0.ROUT, if0.G_OUT}) > 1 || $countones(if0.RIN) > 1) begin
            n_fail++;
            $display("FAIL inv_h0 t=%0t drivers=%b rin=%b required <=1 each", $time,
                     {if0.EXT_OUT, if0.ROUT, if0.G_OUT}, if0.RIN);
         end
         n_tests++;
         if ($countones({if1.EXT_OUT, if1.ROUT, if1.G_OUT}) > 1 || $countones(if1.RIN) > 1) begin
            n_fail++;
            $display("FAIL inv_h1 t=%0t drivers=%b rin=%b required <=1 each", $time,
                     {if1.EXT_OUT, if1.ROUT, if1.G_OUT}, if1.RIN);
         end
         n_tests++;
         if ($countones({if3.EXT_OUT, if3.ROUT, if3.G_OUT}) > 1 || $countones(if3.RIN) > 1) begin
            n_fail++;
            $display("FAIL inv_h3 t=%0t drivers=%b rin=%b required <=1 each", $time,
                     {if3.EXT_OUT, if3.ROUT, if3.G_OUT}, if3.RIN);
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RESETb = 1'b0;
      #12;
      n_tests++;
      if (if0.TIME !== 2'd0 || if0.DONE !== 1'b0 || ctl0 !== 15'd0) begin
         n_fail++;
         $display("FAIL reset: time=%0d done=%b ctl=%b required 0/0/0", if0.TIME, if0.DONE, ctl0);
      end
      @(posedge CLK);
      #1 RESETb = 1'b1;
   endtask

   task automatic test_load();
      if0.INSTR = 10'b000_10_00_000;
      if0.EXEC  = 1'b1;
      tick();
      if0.EXEC = 1'b0;
      n_tests++;
      if (if0.TIME !== 2'd1 || ctl0 !== {1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0, 3'b000}) begin
         n_fail++;
         $display("FAIL load_t1: time=%0d ctl=%b required 1 / ext_out rin=0100", if0.TIME, ctl0);
      end
      tick();
      n_tests++;
      if (if0.TIME !== 2'd0 || if0.DONE !== 1'b1 || ctl0 !== 15'd0) begin
         n_fail++;
         $display("FAIL load_done: time=%0d done=%b ctl=%b required 0/1/0", if0.TIME, if0.DONE, ctl0);
      end
   endtask

   task automatic test_add();
      if0.INSTR = 10'b010_00_11_000;
      if0.EXEC  = 1'b1;
      tick();
      if0.EXEC = 1'b0;
      n_tests++;
      if (if0.TIME !== 2'd1 || if0.DONE !== 1'b0 ||
          ctl0 !== {1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 3'b000}) begin
         n_fail++;
         $display("FAIL add_t1: time=%0d done=%b ctl=%b required rout=0001 a_ld", if0.TIME, if0.DONE, ctl0);
      end
      tick();
      n_tests++;
      if (if0.TIME !== 2'd2 || ctl0 !== {1'b0, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 3'b010}) begin
         n_fail++;
         $display("FAIL add_t2: time=%0d ctl=%b required rout=1000 g_ld op=010", if0.TIME, ctl0);
      end
      tick();
      n_tests++;
      if (if0.TIME !== 2'd3 || ctl0 !== {1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 3'b000}) begin
         n_fail++;
         $display("FAIL add_t3: time=%0d ctl=%b required g_out rin=0001", if0.TIME, ctl0);
      end
      tick();
      tick();
      n_tests++;
      if (if0.TIME !== 2'd0 || if0.DONE !== 1'b1 || ctl0 !== 15'd0) begin
         n_fail++;
         $display("FAIL add_done_hold: time=%0d done=%b ctl=%b required 0/1/0", if0.TIME, if0.DONE, ctl0);
      end
      if0.INSTR = 10'b000_01_00_000;
      if0.EXEC  = 1'b1;
      tick();
      if0.EXEC = 1'b0;
      n_tests++;
      if (if0.TIME !== 2'd1 || if0.DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL add_done_clear: time=%0d done=%b required 1/0", if0.TIME, if0.DONE);
      end
      tick();
   endtask

   task automatic test_hold_inv();
      logic [14:0] exp;
      logic        fin;
      if2.INSTR = 10'b111_10_00_000;
      if2.EXEC  = 1'b1;
      tick();
      if2.EXEC = 1'b0;
      for (int s = 1; s <= 3; s++) begin
         for (int c = 0; c < 3; c++) begin
            fin = (c == 2);
            case (s)
               1:       exp = {1'b0, 4'b0100, 4'b0000, fin, 1'b0, 1'b0, 3'b000};
               2:       exp = {1'b0, 4'b0000, 4'b0000, 1'b0, fin, 1'b0, 3'b111};
               default: exp = {1'b0, 4'b0000, fin ? 4'b0100 : 4'b0000, 1'b0, 1'b0, 1'b1, 3'b000};
            endcase
            n_tests++;
            if (if2.TIME !== 2'(s) || ctl2 !== exp) begin
               n_fail++;
               $display("FAIL hold_inv T%0d c%0d: time=%0d ctl=%b required %0d/%b", s, c, if2.TIME, ctl2, s, exp);
            end
            tick();
         end
      end
      n_tests++;
      if (if2.TIME !== 2'd0 || if2.DONE !== 1'b1 || ctl2 !== 15'd0) begin
         n_fail++;
         $display("FAIL hold_inv_done: time=%0d done=%b ctl=%b required 0/1/0", if2.TIME, if2.DONE, ctl2);
      end
   endtask

   task automatic test_exec_ignored();
      if0.INSTR = 10'b011_01_10_000;
      if0.EXEC  = 1'b1;
      tick();
      if0.EXEC = 1'b0;
      tick();
      if0.INSTR = 10'b000_11_00_000;
      if0.EXEC  = 1'b1;
      n_tests++;
      if (if0.TIME !== 2'd2 || ctl0 !== {1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, 3'b011}) begin
         n_fail++;
         $display("FAIL sub_t2: time=%0d ctl=%b required rout=0100 g_ld op=011", if0.TIME, ctl0);
      end
      tick();
      if0.EXEC = 1'b0;
      n_tests++;
      if (if0.TIME !== 2'd3 || ctl0 !== {1'b0, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b1, 3'b000}) begin
         n_fail++;
         $display("FAIL sub_t3: time=%0d ctl=%b required g_out rin=0010", if0.TIME, ctl0);
      end
      tick();
      n_tests++;
      if (if0.TIME !== 2'd0 || if0.DONE !== 1'b1) begin
         n_fail++;
         $display("FAIL sub_done: time=%0d done=%b required 0/1", if0.TIME, if0.DONE);
      end
   endtask

   task automatic test_reset_mid();
      if0.INSTR = 10'b101_01_10_000;
      if0.EXEC  = 1'b1;
      tick();
      if0.EXEC = 1'b0;
      tick();
      n_tests++;
      if (if0.TIME !== 2'd2 || if0.ALU_OP !== 3'b101) begin
         n_fail++;
         $display("FAIL or_t2: time=%0d op=%b required 2/101", if0.TIME, if0.ALU_OP);
      end
      #3 RESETb = 1'b0;
      #1;
      n_tests++;
      if (if0.TIME !== 2'd0 || if0.DONE !== 1'b0 || ctl0 !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_mid: time=%0d done=%b ctl=%b required 0/0/0", if0.TIME, if0.DONE, ctl0);
      end
      @(posedge CLK);
      #1 RESETb = 1'b1;
      if0.INSTR = 10'b001_11_01_000;
      if0.EXEC  = 1'b1;
      tick();
      if0.EXEC = 1'b0;
      n_tests++;
      if (if0.TIME !== 2'd1 || ctl0 !== {1'b0, 4'b0010, 4'b1000, 1'b0, 1'b0, 1'b0, 3'b000}) begin
         n_fail++;
         $display("FAIL mov_after_reset: time=%0d ctl=%b required rout=0010 rin=1000", if0.TIME, ctl0);
      end
      tick();
      n_tests++;
      if (if0.TIME !== 2'd0 || if0.DONE !== 1'b1) begin
         n_fail++;
         $display("FAIL mov_done: time=%0d done=%b required 0/1", if0.TIME, if0.DONE);
      end
   endtask

   task automatic test_back_to_back();
      if0.INSTR = 10'b000_01_00_111;
      if0.EXEC  = 1'b1;
      tick();
      n_tests++;
      if (if0.TIME !== 2'd1 || ctl0 !== {1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0, 3'b000}) begin
         n_fail++;
         $display("FAIL b2b_first: time=%0d ctl=%b required ext_out rin=0010", if0.TIME, ctl0);
      end
      tick();
      n_tests++;
      if (if0.TIME !== 2'd0 || if0.DONE !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_t0: time=%0d done=%b required 0/1", if0.TIME, if0.DONE);
      end
      tick();
      if0.EXEC = 1'b0;
      n_tests++;
      if (if0.TIME !== 2'd1 || if0.DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_reaccept: time=%0d done=%b required 1/0", if0.TIME, if0.DONE);
      end
      tick();
   endtask

   task automatic test_random_stream();
      logic [9:0] instr;
      int         steps;
      int         len0, len1, len3;
      chk_en = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         instr = 10'($urandom);
         steps = (instr[9:8] == 2'b00) ? 1 : 3;
         if0.INSTR = instr; if1.INSTR = instr; if3.INSTR = instr;
         if0.EXEC = 1'b1;   if1.EXEC = 1'b1;   if3.EXEC = 1'b1;
         tick();
         if0.EXEC = 1'b0;   if1.EXEC = 1'b0;   if3.EXEC = 1'b0;
         if0.INSTR = ~instr; if1.INSTR = ~instr; if3.INSTR = ~instr;
         len0 = 0; len1 = 0; len3 = 0;
         for (int k = 1; k <= 20; k++) begin
            tick();
            if (len0 == 0 && if0.TIME == 2'd0) len0 = k;
            if (len1 == 0 && if1.TIME == 2'd0) len1 = k;
            if (len3 == 0 && if3.TIME == 2'd0) len3 = k;
            if (len0 != 0 && len1 != 0 && len3 != 0) break;
         end
         n_tests++;
         if (len0 != steps || len1 != 2 * steps || len3 != 4 * steps ||
             if0.DONE !== 1'b1 || if1.DONE !== 1'b1 || if3.DONE !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_len i=%0d instr=%b: len=%0d/%0d/%0d done=%b%b%b required %0d/%0d/%0d done=111",
                     i, instr, len0, len1, len3, if0.DONE, if1.DONE, if3.DONE, steps, 2 * steps, 4 * steps);
         end
      end
      chk_en = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      chk_en  = 1'b0;
      RESETb  = 1'b0;
      if0.EXEC = 1'b0; if1.EXEC = 1'b0; if2.EXEC = 1'b0; if3.EXEC = 1'b0;
      if0.INSTR = '0;  if1.INSTR = '0;  if2.INSTR = '0;  if3.INSTR = '0;
      test_reset();
      test_load();
      test_add();
      test_hold_inv();
      test_exec_ignored();
      test_reset_mid();
      test_back_to_back();
      test_random_stream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
